serial_addsub_ctrl: RTL and testbench
=====================================

# serial_addsub_ctrl

Bit-serial adder/subtractor controller that sequences a single gate-level full-adder cell over WIDTH clock cycles to produce a WIDTH-bit sum or difference. It latches two operands on a start handshake and shifts them LSB-first through the cell, holding the running carry in a flip-flop. It reports unsigned carry/borrow and signed overflow. It sits between the lab's operand registers and the result display path, trading latency for one adder cell instead of a ripple chain.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  request a new operation; sampled only in IDLE or DONE.
- sub  in  1  0 = a+b, 1 = a−b; sampled with start.
- a  in  WIDTH  operand A; sampled with start.
- b  in  WIDTH  operand B; sampled with start.
- busy  out  1  high while bits are being processed.
- done  out  1  one-cycle pulse when result/cout/ovf become valid.
- result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- cout  out  1  final carry out; for subtract, 1 = no borrow.
- ovf  out  1  two's-complement overflow.

One clock; reset is synchronous and active-high.

## Operation
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1:
  - Load shift register A ← a.
  - Load shift register B ← (sub ? ~b : b).
  - Load carry flop ← sub.
  - Clear bit counter and result register; go to RUN.
- IDLE/DONE with start=0:
  - DONE → IDLE; IDLE stays.
  - result, cout and ovf hold their values.
- RUN, each cycle:
  - Full-adder inputs: a=A[0], b=B[0], ci=carry.
  - Shift A and B right by one.
  - Shift the sum z into result from the MSB end, shifting right, so bit 0 lands in result[0] after WIDTH shifts.
  - carry ← co.
  - When counter = WIDTH−1: capture the carry into the MSB as cin_msb and go to DONE. Otherwise increment the counter.
- Entering DONE: cout ← final carry; ovf ← cin_msb XOR final carry.
- start while in RUN is ignored and not queued. sub, a and b are don't-care outside the start cycle.
- rst at any time: state=IDLE and all registers clear; an in-flight operation is aborted with no done.

## Timing
- Reset values: busy=0, done=0, result=0, cout=0, ovf=0.
- start sampled high at the edge ending cycle 0:
  - busy=1 in cycles 1..WIDTH.
  - done=1 in cycle WIDTH+1 only, with busy=0.
  - Latency from start to done is WIDTH+1 cycles.
- result, cout and ovf are valid from the done cycle until the cycle after the next accepted start. During RUN, result shows partial shift contents.
- Back-to-back operation: start held high during the done cycle is accepted, and busy rises the next cycle with no IDLE gap.
- busy and done are registered outputs and are never high together.
- The bit counter needs $clog2(WIDTH) bits, minimum 1. The carry is a single flop.

## Structure
- Shared package serial_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default width constant DEF_WIDTH = 8.
- Exactly one instance of the team's gate-level full-adder cell `add` (ports a, b, ci, z, co) is the only arithmetic in the block. No behavioural + or − is allowed.
- Controller FSM, counter, shift registers and carry flop live in serial_addsub_ctrl. No further sub-modules.

## Test plan
All scenarios use WIDTH=8.
- 0x35 + 0x1A, sub=0 → done 9 cycles after start; result=0x4F, cout=0, ovf=0.
- 0xFF + 0x01 → result=0x00, cout=1, ovf=0. Then 0x7F + 0x01 → result=0x80, cout=0, ovf=1.
- sub=1: 0x10 − 0x20 → result=0xF0, cout=0 (borrow), ovf=0. Then 0x80 − 0x01 → result=0x7F, cout=1, ovf=1.
- start pulsed with a=0x01, b=0x01; second start in RUN cycle 3 with a=0xAA, b=0x55 → ignored; result=0x02, and exactly one done.
- start held high through done → second operation begins in the following cycle; busy low only in the done cycle.
- rst asserted in RUN cycle 4 → next cycle busy=0, done=0, result=0, cout=0, ovf=0; no done pulse. A fresh start then computes correctly.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the bit-serial add/subtract controller.
package serial_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Gate-style incrementer so the full-adder cell stays the only adder in the block.
    function automatic logic [31:0] incr(input logic [31:0] v);
        logic [31:0] r;
        logic        c;
        c = 1'b1;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[i] ^ c;
            c    = c & v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/add.sv
// Gate-level full-adder cell: z = a ^ b ^ ci, co = majority(a, b, ci).
module add (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic z,
    output logic co
);

    logic p, g, t;

    xor u_p  (p, a, b);
    xor u_z  (z, p, ci);
    and u_g  (g, a, b);
    and u_t  (t, p, ci);
    or  u_co (co, g, t);

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell walked LSB-first over WIDTH cycles.
module serial_addsub_ctrl
    import serial_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             fa_z, fa_co;
    logic             accept, last;

    assign accept = start && (state_q != RUN);
    assign last   = (cnt_q == CW'(WIDTH - 1));

    add u_add (
        .a  (sa_q[0]),
        .b  (sb_q[0]),
        .ci (carry_q),
        .z  (fa_z),
        .co (fa_co)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last)  state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    // Subtract is a + ~b + 1: invert B at load and seed the carry with sub.
    always_comb begin
        cnt_d   = cnt_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            sa_d    = a;
            sb_d    = sub ? ~b : b;
            carry_d = sub;
            cnt_d   = '0;
            res_d   = '0;
        end else if (state_q == RUN) begin
            sa_d    = {1'b0, sa_q[WIDTH-1:1]};
            sb_d    = {1'b0, sb_q[WIDTH-1:1]};
            res_d   = {fa_z, res_q[WIDTH-1:1]};
            carry_d = fa_co;
            if (last) begin
                // carry_q here is the carry into the MSB.
                cout_d = fa_co;
                ovf_d  = carry_q ^ fa_co;
            end else begin
                cnt_d = CW'(incr(32'(cnt_q)));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            sa_q    <= '0;
            sb_q    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign result = res_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl at WIDTH=8; inputs change and outputs are sampled on negedge.
module tb_serial_addsub_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       sub;
    logic [7:0] a, b;
    logic       busy, done, cout, ovf;
    logic [7:0] result;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    serial_addsub_ctrl #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sub    (sub),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},   32'(busy),   32'd0);
        check({tag, "_done"},   32'(done),   32'd0);
        check({tag, "_result"}, 32'(result), 32'd0);
        check({tag, "_cout"},   32'(cout),   32'd0);
        check({tag, "_ovf"},    32'(ovf),    32'd0);
    endtask

    // Waits from cycle 1 after the start edge until done; returns cycle index of done.
    task automatic wait_done(output int n, output bit busy_ok);
        n = 1;
        busy_ok = 1'b1;
        while (!done && n < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic sv, input logic [7:0] er, input logic ec, input logic eo);
        int n;
        bit bok;
        @(negedge clk);
        start = 1'b1; a = av; b = bv; sub = sv;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
        wait_done(n, bok);
        check({tag, "_lat"},    32'(n),      32'd9);
        check({tag, "_busy"},   32'(bok),    32'd1);
        check({tag, "_dbusy"},  32'(busy),   32'd0);
        check({tag, "_result"}, 32'(result), 32'(er));
        check({tag, "_cout"},   32'(cout),   32'(ec));
        check({tag, "_ovf"},    32'(ovf),    32'(eo));
    endtask

    initial begin
        int n, ndone, first;
        bit bok;
        logic [7:0] r_at_done;

        rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;

        run_op("add_35_1a", 8'h35, 8'h1A, 1'b0, 8'h4F, 1'b0, 1'b0);
        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_op("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Hold: outputs keep their values in IDLE.
        repeat (3) @(negedge clk);
        check("hold_result", 32'(result), 32'h7F);
        check("hold_cout",   32'(cout),   32'd1);
        check("hold_ovf",    32'(ovf),    32'd1);

        // Start during RUN is ignored.
        start = 1'b1; a = 8'h01; b = 8'h01; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        ndone = 0; first = 0; r_at_done = '0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) begin start = 1'b1; a = 8'hAA; b = 8'h55; end
            else start = 1'b0;
            if (done) begin
                ndone++;
                if (first == 0) begin first = c; r_at_done = result; end
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("ign_ndone",  32'(ndone),     32'd1);
        check("ign_lat",    32'(first),     32'd9);
        check("ign_result", 32'(r_at_done), 32'h02);

        // Back-to-back: start held through the done cycle.
        start = 1'b1; a = 8'h35; b = 8'h1A; sub = 1'b0;
        @(negedge clk);
        wait_done(n, bok);
        check("b2b1_lat",    32'(n),      32'd9);
        check("b2b1_busy",   32'(bok),    32'd1);
        check("b2b1_result", 32'(result), 32'h4F);
        a = 8'h0F; b = 8'h01;
        @(negedge clk);
        check("b2b_nogap", 32'(busy), 32'd1);
        start = 1'b0;
        wait_done(n, bok);
        check("b2b2_lat",    32'(n),      32'd9);
        check("b2b2_result", 32'(result), 32'h10);

        // Reset mid-run after an op that left cout/ovf set.
        run_op("sub_80_01b", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; sub = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_zero("rst_run");
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("rst_nodone", 32'(ndone), 32'd0);
        run_op("post_rst", 8'h35, 8'h1A, 1'b0, 8'h4F, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
